// File: rtl/nerf_fifo_pkg.sv
// Shared constants and gray-code helpers for the NERF clock-domain-crossing FIFOs.
package nerf_fifo_pkg;

  localparam logic [15:0] SPKID_EMPTY_WORD = 16'hFFFF;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix-XOR from the MSB down; the upper bits are zero for narrower pointers.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    bin = bin ^ (bin >> 1);
    bin = bin ^ (bin >> 2);
    bin = bin ^ (bin >> 4);
    bin = bin ^ (bin >> 8);
    bin = bin ^ (bin >> 16);
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for a gray-coded FIFO pointer entering the clk domain.
module gray_ptr_sync #(
  parameter int AW          = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_domain,
  input  logic [AW:0]   gray_in,
  output logic [AW:0]   gray_out
);

  logic [AW:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset_domain) begin
    if (reset_domain) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spkid_pipe_fifo.sv
// Dual-clock spike-ID FIFO between neuron_pool (wr_clk) and okBTPipeOut (rd_clk),
// with block-granular readiness, saturating drop counter and sticky underrun flag.
module spkid_pipe_fifo
  import nerf_fifo_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 10,
  parameter int BLOCK_WORDS = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic          wr_clk,
  input  logic          rd_clk,
  input  logic          reset_global,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_full,
  output logic [15:0]   drop_cnt,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   rd_count,
  output logic          blk_ready,
  output logic          underrun
);

  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  // wr_en/rd_en are single-cycle strobes: a word moves on every edge where the strobe
  // is high and the FIFO can accept/supply it; otherwise it becomes a drop or an underrun.

  logic [1:0]    wr_rst_q, rd_rst_q;
  logic          wr_rst, rd_rst;
  logic [AW:0]   wr_bin, wr_gray, wr_bin_nxt, rd_gray_ws;
  logic [AW:0]   rd_bin, rd_gray, rd_bin_nxt, wr_gray_rs, wr_sync_bin, count_nxt;
  logic          wr_do, rd_do, rd_empty;
  logic [DW-1:0] mem [DEPTH];

  // Reset asserts asynchronously and releases on each domain's own clock.
  always_ff @(posedge wr_clk or posedge reset_global) begin
    if (reset_global) wr_rst_q <= 2'b11;
    else              wr_rst_q <= {wr_rst_q[0], 1'b0};
  end

  always_ff @(posedge rd_clk or posedge reset_global) begin
    if (reset_global) rd_rst_q <= 2'b11;
    else              rd_rst_q <= {rd_rst_q[0], 1'b0};
  end

  assign wr_rst = wr_rst_q[1];
  assign rd_rst = rd_rst_q[1];

  gray_ptr_sync #(.AW(AW), .SYNC_STAGES(SYNC_STAGES)) u_sync_rd2wr (
    .clk          (wr_clk),
    .reset_domain (wr_rst),
    .gray_in      (rd_gray),
    .gray_out     (rd_gray_ws)
  );

  gray_ptr_sync #(.AW(AW), .SYNC_STAGES(SYNC_STAGES)) u_sync_wr2rd (
    .clk          (rd_clk),
    .reset_domain (rd_rst),
    .gray_in      (wr_gray),
    .gray_out     (wr_gray_rs)
  );

  // Write domain
  assign wr_full    = (wr_gray == {~rd_gray_ws[AW:AW-1], rd_gray_ws[AW-2:0]});
  assign wr_do      = wr_en & ~wr_full;
  assign wr_bin_nxt = wr_bin + PW'(1);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin   <= '0;
      wr_gray  <= '0;
      drop_cnt <= '0;
    end else if (wr_do) begin
      wr_bin  <= wr_bin_nxt;
      wr_gray <= PW'(bin2gray(32'(wr_bin_nxt)));
    end else if (wr_en && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_do) mem[wr_bin[AW-1:0]] <= wr_data;
  end

  // Read domain; count and readiness use the post-read pointer so they never overstate.
  assign rd_empty    = (rd_gray == wr_gray_rs);
  assign rd_do       = rd_en & ~rd_empty;
  assign rd_bin_nxt  = rd_do ? rd_bin + PW'(1) : rd_bin;
  assign wr_sync_bin = PW'(gray2bin(32'(wr_gray_rs)));
  assign count_nxt   = wr_sync_bin - rd_bin_nxt;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin    <= '0;
      rd_gray   <= '0;
      rd_count  <= '0;
      blk_ready <= 1'b0;
      rd_data   <= DW'(SPKID_EMPTY_WORD);
      underrun  <= 1'b0;
    end else begin
      rd_bin    <= rd_bin_nxt;
      rd_gray   <= PW'(bin2gray(32'(rd_bin_nxt)));
      rd_count  <= count_nxt;
      blk_ready <= (count_nxt >= PW'(BLOCK_WORDS));
      if (rd_do) begin
        rd_data <= mem[rd_bin[AW-1:0]];
      end else if (rd_en) begin
        rd_data  <= DW'(SPKID_EMPTY_WORD);
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spkid_pipe_fifo.sv
// Directed bench for spkid_pipe_fifo: block readiness, full/drop, underrun,
// concurrent traffic against a scoreboard queue, mid-burst reset, drop saturation.
`timescale 1ns/100ps
module tb_spkid_pipe_fifo;

  logic        wr_clk = 1'b0;
  logic        rd_clk = 1'b0;
  logic        reset_global;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        wr_full;
  logic [15:0] drop_cnt;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [10:0] rd_count;
  logic        blk_ready;
  logic        underrun;

  int          errors = 0;
  int          checks = 0;
  int          wr_total, rd_total;
  logic [15:0] exp_q[$];
  real         rd_half = 5.0;

  // clock / reset
  always #10.4 wr_clk = ~wr_clk;
  always begin
    #(rd_half);
    rd_clk = ~rd_clk;
  end

  spkid_pipe_fifo #(.DW(16), .AW(10), .BLOCK_WORDS(256), .SYNC_STAGES(2)) dut (
    .wr_clk       (wr_clk),
    .rd_clk       (rd_clk),
    .reset_global (reset_global),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .drop_cnt     (drop_cnt),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_count     (rd_count),
    .blk_ready    (blk_ready),
    .underrun     (underrun)
  );

  initial begin
    #10ms;
    $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic apply_reset();
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    reset_global = 1'b0; #1;
    reset_global = 1'b1; #40;
    reset_global = 1'b0;
    repeat (4) @(posedge wr_clk);
    repeat (4) @(posedge rd_clk);
  endtask

  task automatic wr_align(); @(posedge wr_clk); #1; endtask
  task automatic rd_align(); @(posedge rd_clk); #1; endtask

  task automatic wr_word(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    @(posedge wr_clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_word(output logic [15:0] d);
    rd_en = 1'b1;
    @(posedge rd_clk); #1;
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic wait_count(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (int'(rd_count) >= n) begin ok = 1'b1; break; end
      rd_align();
    end
  endtask

  // scenarios
  task automatic test_reset();
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    reset_global = 1'b0; #1;
    reset_global = 1'b1; #30;
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full: got %b exp 0", wr_full); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt: got %h exp 0000", drop_cnt); end
    checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL reset_rd_data: got %h exp FFFF", rd_data); end
    checks++; if (rd_count !== 11'd0) begin errors++; $display("FAIL reset_rd_count: got %0d exp 0", rd_count); end
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL reset_blk_ready: got %b exp 0", blk_ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b exp 0", underrun); end
    reset_global = 1'b0;
    repeat (4) @(posedge wr_clk);
    rd_align();
    checks++; if (rd_count !== 11'd0 || wr_full !== 1'b0) begin errors++; $display("FAIL post_reset_idle: rd_count=%0d wr_full=%b exp 0/0", rd_count, wr_full); end
  endtask

  task automatic test_block();
    logic [15:0] d;
    bit ok;
    apply_reset();
    wr_align();
    for (int i = 0; i < 255; i++) wr_word(16'(i));
    repeat (20) rd_align();
    checks++; if (rd_count !== 11'd255) begin errors++; $display("FAIL blk_count_255: got %0d exp 255", rd_count); end
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL blk_ready_at_255: got %b exp 0", blk_ready); end
    wr_align();
    wr_word(16'd255);
    rd_align();
    wait_count(256, ok);
    checks++; if (!ok) begin errors++; $display("FAIL blk_wait: rd_count=%0d never reached 256", rd_count); end
    checks++; if (blk_ready !== 1'b1 || rd_count !== 11'd256) begin errors++; $display("FAIL blk_ready_at_256: got blk=%b count=%0d exp 1/256", blk_ready, rd_count); end
    for (int i = 0; i < 256; i++) begin
      rd_word(d);
      checks++; if (d !== 16'(i)) begin errors++; $display("FAIL blk_data[%0d]: got %h exp %h", i, d, 16'(i)); end
      if (i == 0) begin
        checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL blk_ready_after_first_read: got %b exp 0", blk_ready); end
      end
    end
    rd_align();
    checks++; if (rd_count !== 11'd0) begin errors++; $display("FAIL blk_count_end: got %0d exp 0", rd_count); end
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL blk_ready_end: got %b exp 0", blk_ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL blk_underrun: got %b exp 0", underrun); end
  endtask

  task automatic test_full();
    logic [15:0] d;
    bit ok;
    apply_reset();
    wr_align();
    for (int i = 0; i < 1023; i++) wr_word(16'(i));
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL full_at_1023: got %b exp 0", wr_full); end
    wr_word(16'd1023);
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_at_1024: got %b exp 1", wr_full); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_before: got %0d exp 0", drop_cnt); end
    wr_word(16'hBEEF);
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_after_1025: got %0d exp 1", drop_cnt); end
    rd_align();
    wait_count(1024, ok);
    checks++; if (!ok || rd_count !== 11'd1024) begin errors++; $display("FAIL full_count: got %0d exp 1024", rd_count); end
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL full_blk_ready: got %b exp 1", blk_ready); end
    for (int i = 0; i < 1024; i++) begin
      rd_word(d);
      checks++; if (d !== 16'(i)) begin errors++; $display("FAIL full_data[%0d]: got %h exp %h", i, d, 16'(i)); end
    end
    repeat (10) wr_align();
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b exp 0", wr_full); end
    rd_align();
    checks++; if (rd_count !== 11'd0) begin errors++; $display("FAIL full_count_end: got %0d exp 0", rd_count); end
  endtask

  task automatic test_underrun();
    logic [15:0] d;
    bit ok;
    apply_reset();
    rd_align();
    rd_word(d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL under_data: got %h exp FFFF", d); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_flag: got %b exp 1", underrun); end
    checks++; if (rd_count !== 11'd0) begin errors++; $display("FAIL under_count: got %0d exp 0", rd_count); end
    wr_align();
    wr_word(16'h1234);
    rd_align();
    wait_count(1, ok);
    rd_word(d);
    checks++; if (!ok || d !== 16'h1234) begin errors++; $display("FAIL under_then_data: got %h exp 1234", d); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL under_sticky: got %b exp 1", underrun); end
    rd_word(d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL under_again: got %h exp FFFF", d); end
  endtask

  task automatic writer(input int n, input int wgap);
    logic [15:0] d;
    int cyc = 0;
    wr_align();
    for (int i = 0; i < n && cyc < 40000; ) begin
      cyc++;
      if ($urandom_range(0, wgap) != 0 || wr_full) begin
        wr_align();
      end else begin
        d = 16'($urandom_range(0, 65535));
        exp_q.push_back(d);
        wr_word(d);
        wr_total++;
        i++;
      end
    end
  endtask

  task automatic reader(input int n, input int rgap);
    logic [15:0] d;
    int cyc = 0;
    rd_align();
    while (rd_total < n && cyc < 40000) begin
      cyc++;
      checks++;
      if (int'(rd_count) > wr_total - rd_total) begin
        errors++; $display("FAIL conc_count_early: rd_count=%0d exceeds written-read=%0d", rd_count, wr_total - rd_total);
      end
      if (rd_count != 11'd0 && $urandom_range(0, rgap) == 0) begin
        rd_word(d);
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL conc_data: got %h exp nothing queued", d);
        end else begin
          if (d !== exp_q[0]) begin errors++; $display("FAIL conc_data[%0d]: got %h exp %h", rd_total, d, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        rd_total++;
      end else begin
        rd_align();
      end
    end
    checks++; if (rd_total != n) begin errors++; $display("FAIL conc_timeout: read %0d exp %0d", rd_total, n); end
  endtask

  task automatic test_concurrent();
    int n_tab[3]    = '{600, 1500, 600};
    int wgap_tab[3] = '{0, 0, 3};
    int rgap_tab[3] = '{0, 5, 1};
    logic [15:0] drop0;
    apply_reset();
    exp_q.delete();
    for (int p = 0; p < 3; p++) begin
      wr_total = 0; rd_total = 0;
      drop0 = drop_cnt;
      fork
        writer(n_tab[p], wgap_tab[p]);
        reader(n_tab[p], rgap_tab[p]);
      join
      checks++; if (drop_cnt !== drop0) begin errors++; $display("FAIL conc_drop[%0d]: got %0d exp %0d", p, drop_cnt, drop0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL conc_leftover[%0d]: got %0d exp 0", p, exp_q.size()); end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL conc_underrun: got %b exp 0", underrun); end
  endtask

  task automatic test_reset_midburst();
    logic [15:0] d;
    bit ok;
    apply_reset();
    rd_align();
    rd_word(d);
    wr_align();
    for (int i = 0; i < 500; i++) wr_word(16'h4000 + 16'(i));
    rd_align();
    wait_count(1, ok);
    rd_word(d);
    checks++; if (d !== 16'h4000 || underrun !== 1'b1) begin errors++; $display("FAIL mid_pre: got %h/%b exp 4000/1", d, underrun); end
    wr_align();
    wr_en = 1'b1; wr_data = 16'h7777;
    #3 reset_global = 1'b1;
    #30;
    checks++; if (wr_full !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_wr_side: got full=%b drop=%0d exp 0/0", wr_full, drop_cnt); end
    checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL mid_rd_data: got %h exp FFFF", rd_data); end
    checks++; if (rd_count !== 11'd0 || blk_ready !== 1'b0) begin errors++; $display("FAIL mid_count: got %0d/%b exp 0/0", rd_count, blk_ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun: got %b exp 0", underrun); end
    wr_en = 1'b0;
    reset_global = 1'b0;
    repeat (4) @(posedge wr_clk);
    repeat (10) rd_align();
    checks++; if (rd_count !== 11'd0) begin errors++; $display("FAIL mid_release_count: got %0d exp 0", rd_count); end
    wr_align();
    for (int i = 0; i < 256; i++) wr_word(16'h8000 + 16'(i));
    rd_align();
    wait_count(256, ok);
    checks++; if (!ok || blk_ready !== 1'b1 || rd_count !== 11'd256) begin errors++; $display("FAIL mid_refill: got count=%0d blk=%b exp 256/1", rd_count, blk_ready); end
    for (int i = 0; i < 256; i++) begin
      rd_word(d);
      checks++; if (d !== 16'h8000 + 16'(i)) begin errors++; $display("FAIL mid_data[%0d]: got %h exp %h", i, d, 16'h8000 + 16'(i)); end
    end
  endtask

  task automatic test_drop_sat();
    apply_reset();
    rd_half = 500.0;
    wr_align();
    wr_en = 1'b1; wr_data = 16'hAAAA;
    repeat (1024 + 65534) @(posedge wr_clk);
    #1;
    checks++; if (drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h exp FFFE", drop_cnt); end
    @(posedge wr_clk); #1;
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h exp FFFF", drop_cnt); end
    repeat (5) @(posedge wr_clk);
    #1;
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h exp FFFF", drop_cnt); end
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL sat_full: got %b exp 1", wr_full); end
    wr_en = 1'b0;
    rd_half = 5.0;
  endtask

  initial begin
    test_reset();
    test_block();
    test_full();
    test_underrun();
    test_concurrent();
    test_reset_midburst();
    test_drop_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
